// File: rtl/invader_formation_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : invader_formation_ctrl_if
// Brief    : Renderer/game-side bundle for the invader formation controller.
// Revision : 1.0
// ============================================================================
interface invader_formation_ctrl_if #(
    parameter int NUM_INVADERS = 10
);
    logic                          vblnk;
    logic                          start;
    logic                          bullet_valid;
    logic [11:0]                   bullet_x;
    logic [11:0]                   bullet_y;
    logic [NUM_INVADERS-1:0][11:0] invader_x_positions;
    logic [9:0]                    xpos;
    logic [9:0]                    ypos;
    logic [NUM_INVADERS-1:0]       invader_enable;
    logic                          bullet_hit;
    logic [3:0]                    hit_index;
    logic                          all_destroyed;
    logic                          invaded;

    modport master (
        output vblnk, start, bullet_valid, bullet_x, bullet_y, invader_x_positions,
        input  xpos, ypos, invader_enable, bullet_hit, hit_index, all_destroyed, invaded
    );

    modport slave (
        input  vblnk, start, bullet_valid, bullet_x, bullet_y, invader_x_positions,
        output xpos, ypos, invader_enable, bullet_hit, hit_index, all_destroyed, invaded
    );
endinterface
`default_nettype wire

// File: rtl/invader_formation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : invader_formation_ctrl
// Brief    : Steps an invader row across/down the screen, resolves bullet hits.
// Revision : 1.0
// ============================================================================
module invader_formation_ctrl #(
    parameter int NUM_INVADERS    = 10,
    parameter int INVADER_WIDTH   = 64,
    parameter int INVADER_HEIGHT  = 48,
    parameter int Y_INIT          = 100,
    parameter int X_RANGE         = 100,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 16,
    parameter int Y_LIMIT         = 400,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic                    clk65MHz,
    input  logic                    rst_n,
    invader_formation_ctrl_if.slave bus
);
    localparam int c_CNT_W = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_MOVE_RIGHT = 3'd1;
    localparam logic [2:0] c_MOVE_LEFT  = 3'd2;
    localparam logic [2:0] c_DESCEND    = 3'd3;
    localparam logic [2:0] c_CLEARED    = 3'd4;
    localparam logic [2:0] c_INVADED    = 3'd5;

    logic [2:0]              r_state, w_state_nxt;
    logic                    r_vblnk_d;
    logic [c_CNT_W-1:0]      r_frame_cnt, w_frame_cnt_nxt;
    logic                    r_from_right, w_from_right_nxt;
    logic [9:0]              r_xpos, w_xpos_nxt;
    logic [9:0]              r_ypos, w_ypos_nxt;
    logic [NUM_INVADERS-1:0] r_enable, w_enable_nxt;
    logic                    r_bullet_hit, w_bullet_hit_nxt;
    logic [3:0]              r_hit_index, w_hit_index_nxt;
    logic                    r_all_destroyed, w_all_destroyed_nxt;
    logic                    r_invaded, w_invaded_nxt;

    logic                    w_tick;
    logic                    w_active;
    logic                    w_step;
    logic [c_CNT_W-1:0]      w_destroyed;
    logic [c_CNT_W-1:0]      w_threshold;
    logic [10:0]             w_x_right;
    logic [10:0]             w_y_down;
    logic [12:0]             w_bx, w_by;
    logic [12:0]             w_row_top, w_row_bot;
    logic                    w_y_in;
    logic [NUM_INVADERS-1:0] w_hit_vec;
    logic [NUM_INVADERS-1:0] w_hit_mask;
    logic [3:0]              w_hit_sel;
    logic                    w_any_hit;
    logic [NUM_INVADERS-1:0] w_enable_after_hit;

    assign w_tick   = bus.vblnk & ~r_vblnk_d;
    assign w_active = (r_state == c_MOVE_RIGHT) || (r_state == c_MOVE_LEFT) ||
                      (r_state == c_DESCEND);

    // Each kill shortens the step period by one frame.
    always_comb begin
        w_destroyed = '0;
        for (int i = 0; i < NUM_INVADERS; i++) begin
            w_destroyed = w_destroyed + {{(c_CNT_W-1){1'b0}}, ~r_enable[i]};
        end
    end

    assign w_threshold = c_CNT_W'(FRAMES_PER_STEP - 1) - w_destroyed;
    assign w_step      = w_tick && w_active && (r_frame_cnt >= w_threshold);

    assign w_x_right = {1'b0, r_xpos} + 11'(STEP_X);
    assign w_y_down  = {1'b0, r_ypos} + 11'(STEP_Y);

    // Widened to 13 bits so box edges near 4095 never wrap.
    assign w_bx      = {1'b0, bus.bullet_x};
    assign w_by      = {1'b0, bus.bullet_y};
    assign w_row_top = 13'(Y_INIT) + {3'b000, r_ypos};
    assign w_row_bot = w_row_top + 13'(INVADER_HEIGHT);
    assign w_y_in    = (w_by >= w_row_top) && (w_by < w_row_bot);

    generate
        for (genvar gi = 0; gi < NUM_INVADERS; gi++) begin : g_hit
            logic [12:0] w_left;
            logic [12:0] w_right;
            assign w_left        = {1'b0, bus.invader_x_positions[gi]};
            assign w_right       = w_left + 13'(INVADER_WIDTH);
            assign w_hit_vec[gi] = r_enable[gi] && w_y_in &&
                                   (w_bx >= w_left) && (w_bx < w_right);
        end
    endgenerate

    always_comb begin
        w_hit_sel  = '0;
        w_hit_mask = '0;
        for (int i = NUM_INVADERS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_sel     = 4'(i);
                w_hit_mask    = '0;
                w_hit_mask[i] = 1'b1;
            end
        end
    end

    assign w_any_hit          = |w_hit_vec;
    assign w_enable_after_hit = r_enable & ~w_hit_mask;

    always_comb begin
        w_state_nxt         = r_state;
        w_frame_cnt_nxt     = r_frame_cnt;
        w_from_right_nxt    = r_from_right;
        w_xpos_nxt          = r_xpos;
        w_ypos_nxt          = r_ypos;
        w_enable_nxt        = r_enable;
        w_bullet_hit_nxt    = 1'b0;
        w_hit_index_nxt     = r_hit_index;
        w_all_destroyed_nxt = r_all_destroyed;
        w_invaded_nxt       = r_invaded;

        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_nxt     = c_MOVE_RIGHT;
                    w_frame_cnt_nxt = '0;
                end
            end

            c_CLEARED, c_INVADED: begin
                if (bus.start) begin
                    w_state_nxt         = c_MOVE_RIGHT;
                    w_frame_cnt_nxt     = '0;
                    w_from_right_nxt    = 1'b0;
                    w_xpos_nxt          = '0;
                    w_ypos_nxt          = '0;
                    w_enable_nxt        = '1;
                    w_all_destroyed_nxt = 1'b0;
                    w_invaded_nxt       = 1'b0;
                end
            end

            c_MOVE_RIGHT, c_MOVE_LEFT, c_DESCEND: begin
                if (w_tick) begin
                    w_frame_cnt_nxt = w_step ? '0 : r_frame_cnt + 1'b1;
                end

                if (w_step) begin
                    case (r_state)
                        c_MOVE_RIGHT: begin
                            if (w_x_right > 11'(X_RANGE)) begin
                                w_state_nxt      = c_DESCEND;
                                w_from_right_nxt = 1'b1;
                            end else begin
                                w_xpos_nxt = w_x_right[9:0];
                            end
                        end
                        c_MOVE_LEFT: begin
                            if (r_xpos < 10'(STEP_X)) begin
                                w_state_nxt      = c_DESCEND;
                                w_from_right_nxt = 1'b0;
                            end else begin
                                w_xpos_nxt = r_xpos - 10'(STEP_X);
                            end
                        end
                        default: begin
                            w_ypos_nxt = w_y_down[9:0];
                            if (w_y_down >= 11'(Y_LIMIT)) begin
                                w_state_nxt   = c_INVADED;
                                w_invaded_nxt = 1'b1;
                            end else begin
                                w_state_nxt = r_from_right ? c_MOVE_LEFT : c_MOVE_RIGHT;
                            end
                        end
                    endcase
                end

                // Clearing the last invader wins over any step on the same edge.
                if (bus.bullet_valid && w_any_hit) begin
                    w_bullet_hit_nxt = 1'b1;
                    w_hit_index_nxt  = w_hit_sel;
                    w_enable_nxt     = w_enable_after_hit;
                    if (w_enable_after_hit == '0) begin
                        w_state_nxt         = c_CLEARED;
                        w_all_destroyed_nxt = 1'b1;
                        w_xpos_nxt          = r_xpos;
                        w_ypos_nxt          = r_ypos;
                        w_invaded_nxt       = r_invaded;
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_vblnk_d       <= 1'b0;
            r_frame_cnt     <= '0;
            r_from_right    <= 1'b0;
            r_xpos          <= '0;
            r_ypos          <= '0;
            r_enable        <= '1;
            r_bullet_hit    <= 1'b0;
            r_hit_index     <= '0;
            r_all_destroyed <= 1'b0;
            r_invaded       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_vblnk_d       <= bus.vblnk;
            r_frame_cnt     <= w_frame_cnt_nxt;
            r_from_right    <= w_from_right_nxt;
            r_xpos          <= w_xpos_nxt;
            r_ypos          <= w_ypos_nxt;
            r_enable        <= w_enable_nxt;
            r_bullet_hit    <= w_bullet_hit_nxt;
            r_hit_index     <= w_hit_index_nxt;
            r_all_destroyed <= w_all_destroyed_nxt;
            r_invaded       <= w_invaded_nxt;
        end
    end

    assign bus.xpos           = r_xpos;
    assign bus.ypos           = r_ypos;
    assign bus.invader_enable = r_enable;
    assign bus.bullet_hit     = r_bullet_hit;
    assign bus.hit_index      = r_hit_index;
    assign bus.all_destroyed  = r_all_destroyed;
    assign bus.invaded        = r_invaded;
endmodule
`default_nettype wire

// File: doc/invader_formation_ctrl.md
INVADER_FORMATION_CTRL -- requirements
Module: invader_formation_ctrl

Interface
REQ-001 SHALL have parameter NUM_INVADERS, default 10, number of invaders in the row.
REQ-002 SHALL have parameter INVADER_WIDTH, default 64, invader box width in pixels.
REQ-003 SHALL have parameter INVADER_HEIGHT, default 48, invader box height in pixels.
REQ-004 SHALL have parameter Y_INIT, default 100, row top at ypos=0.
REQ-005 SHALL have parameter X_RANGE, default 100, maximum xpos.
REQ-006 SHALL have parameter STEP_X, default 4, horizontal step in pixels.
REQ-007 SHALL have parameter STEP_Y, default 16, descend step in pixels.
REQ-008 SHALL have parameter Y_LIMIT, default 400, ypos at or above which the game is lost.
REQ-009 SHALL have parameter FRAMES_PER_STEP, default 30, base frames per step; legal values > NUM_INVADERS.
REQ-010 SHALL have port clk65MHz, input, 1, sole clock.
REQ-011 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-012 SHALL have port vblnk, input, 1, renderer vertical blank.
REQ-013 SHALL have port start, input, 1, single-cycle game start/restart pulse.
REQ-014 SHALL have ports bullet_valid (input, 1), bullet_x (input, 12) and bullet_y (input, 12), single-cycle bullet position probe.
REQ-015 SHALL have port invader_x_positions, input, NUM_INVADERS x 12, left edge of each invader as reported by the renderer.
REQ-016 SHALL have ports xpos (output, 10) and ypos (output, 10), formation offsets driven to the renderer.
REQ-017 SHALL have port invader_enable, output, NUM_INVADERS, alive mask driven to the renderer.
REQ-018 SHALL have ports bullet_hit (output, 1, one-cycle pulse) and hit_index (output, 4, index of the invader hit).
REQ-019 SHALL have ports all_destroyed (output, 1) and invaded (output, 1), sticky end-of-game flags.

Function
REQ-020 SHALL detect a frame tick as the vblnk rising edge (previous-cycle vblnk registered); a tick is one cycle wide.
REQ-021 SHALL implement FSM states IDLE, MOVE_RIGHT, MOVE_LEFT, DESCEND, CLEARED and INVADED.
REQ-022 SHALL count frame ticks only in MOVE_RIGHT, MOVE_LEFT and DESCEND, and issue a step when count reaches FRAMES_PER_STEP-1-destroyed_count, then clear the count.
REQ-023 SHALL keep destroyed_count equal to the number of zero bits in invader_enable.
REQ-024 SHALL, on a step in MOVE_RIGHT: if xpos+STEP_X > X_RANGE, go to DESCEND with xpos unchanged; else xpos += STEP_X.
REQ-025 SHALL, on a step in MOVE_LEFT: if xpos < STEP_X, go to DESCEND with xpos unchanged; else xpos -= STEP_X.
REQ-026 SHALL, on a step in DESCEND: ypos += STEP_Y, then go to the direction opposite to the one it came from; if the new ypos >= Y_LIMIT, go to INVADED instead.
REQ-027 SHALL move IDLE to MOVE_RIGHT on start.
REQ-028 SHALL, on start in CLEARED or INVADED, load xpos=0, ypos=0, invader_enable all ones, clear both flags and the frame count, and go to MOVE_RIGHT.
REQ-029 SHALL ignore start in MOVE_RIGHT, MOVE_LEFT and DESCEND.
REQ-030 SHALL, on bullet_valid in MOVE_RIGHT, MOVE_LEFT or DESCEND, test each enabled invader i.
REQ-031 SHALL count invader i as hit when invader_x_positions[i] <= bullet_x < invader_x_positions[i]+INVADER_WIDTH and Y_INIT+ypos <= bullet_y < Y_INIT+ypos+INVADER_HEIGHT, computed at 12 bits or more with no wrap.
REQ-032 SHALL, when invaders overlap, select only the lowest hit index.
REQ-033 SHALL, one cycle after bullet_valid, pulse bullet_hit for 1 cycle, drive hit_index, and clear that invader_enable bit on the same edge.
REQ-034 SHALL leave bullet_hit low and hit_index unchanged on a miss.
REQ-035 SHALL ignore bullet_valid in IDLE, CLEARED and INVADED.
REQ-036 SHALL, when a hit and a step land on the same cycle, apply both; the hit test uses the pre-step ypos.
REQ-037 SHALL, when a hit clears the last enabled bit, go to CLEARED and set all_destroyed on that edge; this overrides any step on that edge.
REQ-038 SHALL set invaded on entry to INVADED.
REQ-039 SHALL hold xpos, ypos and invader_enable constant in CLEARED and INVADED.
REQ-040 SHALL keep all_destroyed and invaded high until start or reset.

Reset
REQ-041 SHALL, on rst_n low at any time (mid-step or mid-hit included), immediately set: state IDLE, xpos=0, ypos=0, invader_enable all ones, bullet_hit=0, hit_index=0, all_destroyed=0, invaded=0, frame count 0, vblnk history 0.

Verification
REQ-042 Reset, start, 30 vblnk rising edges -> xpos=4 after the 30th tick, ypos=0.
REQ-043 Run right until xpos=100, next step -> DESCEND; following step -> ypos=16; subsequent steps -> xpos 96, 92, ...
REQ-044 invader_x_positions[3]=400, ypos=0, bullet_valid with bullet_x=430, bullet_y=120 -> next cycle bullet_hit=1, hit_index=3, invader_enable[3]=0; bullet_y=148 -> no hit.
REQ-045 Hit all 10 invaders in sequence -> step period shrinks by 1 frame per kill; after the 10th kill all_destroyed=1, xpos/ypos frozen; start -> enable=10'h3FF, xpos=0, ypos=0.
REQ-046 Y_LIMIT=32: descend twice -> invaded=1, bullet_valid ignored, no further movement.
REQ-047 Assert rst_n low while bullet_valid is high and a step is due -> all outputs at reset values, no bullet_hit pulse after release.
